// File: rtl/spi_crc_slave.sv
// spi_crc_slave
//   SPI mode-0 (CPOL=0, CPHA=0) slave for the CRC-protected SPI link, living
//   entirely in the clk_s domain. ss_n/sclk/mosi are oversampled through
//   2-FF synchronizers. A frame is DATA_WIDTH payload bits followed by an
//   8-bit CRC, MSB first, in both directions.
//
//   Optional feature (macro SPI_CRC_SLAVE_DROP_BAD_EN):
//     defined   - a frame with a CRC mismatch leaves data_out_slave unchanged
//     undefined - data_out_slave always takes the received payload
//
// Ports
//   clk_s          in  system clock, rising edge
//   rst_n          in  asynchronous reset, active-low
//   ss_n           in  slave select, active-low
//   sclk           in  SPI clock (idle low)
//   mosi           in  master-out data
//   miso           out slave-out data, 0 while idle
//   data_in_slave  in  word returned to the master, latched at ss_n fall
//   data_out_slave out last received payload
//   rx_valid       out one-cycle pulse at frame completion
//   crc_err        out CRC result of the last complete frame (1 = mismatch)
//   busy           out high while the FSM is not idle
//   dbg_state      out current FSM state (0 IDLE, 1 DATA, 2 CRC, 3 DONE)
//
// Handshake: rx_valid is a single-cycle strobe with no back-pressure;
// data_out_slave and crc_err are valid in the rx_valid cycle and hold
// until the next completed frame.
module spi_crc_slave #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [7:0]  CRC_POLY   = 8'h07,
  parameter logic [7:0]  CRC_INIT   = 8'h00
) (
  input  logic                  clk_s,
  input  logic                  rst_n,
  input  logic                  ss_n,
  input  logic                  sclk,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_in_slave,
  output logic [DATA_WIDTH-1:0] data_out_slave,
  output logic                  rx_valid,
  output logic                  crc_err,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = ($clog2(DATA_WIDTH) > 3) ? $clog2(DATA_WIDTH) : 3;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(7);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [2:0]            ss_sync_q, sclk_sync_q;
  logic [1:0]            mosi_sync_q;
  logic [DATA_WIDTH-1:0] tx_sh_q, rx_sh_q, dout_q;
  logic [7:0]            crc_rx_q, crc_tx_q, crc_sh_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  miso_q, rx_valid_q, crc_err_q, fin_q;

  // Bit [1] is the synchronized value, bit [2] its one-cycle delay.
  logic ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s;
  assign ss_fall   =  ss_sync_q[2]   & ~ss_sync_q[1];
  assign ss_rise   = ~ss_sync_q[2]   &  ss_sync_q[1];
  assign sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];
  assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];
  assign mosi_s    =  mosi_sync_q[1];

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = b ^ c[7];
    return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
  endfunction

  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], ss_n};
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
    end
  end

  // FSM: state register
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state. ss_n activity always outranks sclk edges.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (ss_fall) state_d = S_DATA;
      S_DATA: begin
        if (ss_rise) state_d = S_IDLE;
        else if (sclk_rise && bit_cnt_q == LAST_DATA) state_d = S_CRC;
      end
      S_CRC: begin
        if (ss_rise) state_d = S_IDLE;
        else if (sclk_rise && bit_cnt_q == LAST_CRC) state_d = S_DONE;
      end
      S_DONE: if (ss_rise) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy      = (state_q != S_IDLE);
    miso      = (state_q == S_IDLE) ? 1'b0 : miso_q;
    dbg_state = state_q;
  end

  assign data_out_slave = dout_q;
  assign rx_valid       = rx_valid_q;
  assign crc_err        = crc_err_q;

  // Datapath. fin_q marks the cycle after the last CRC bit was captured,
  // so crc_sh_q is complete when the result is published.
  always_ff @(posedge clk_s or negedge rst_n) begin
    if (!rst_n) begin
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      dout_q     <= '0;
      crc_rx_q   <= '0;
      crc_tx_q   <= '0;
      crc_sh_q   <= '0;
      bit_cnt_q  <= '0;
      miso_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      crc_err_q  <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      fin_q      <= 1'b0;
      if (fin_q) begin
        rx_valid_q <= 1'b1;
        crc_err_q  <= (crc_sh_q != crc_rx_q);
`ifdef SPI_CRC_SLAVE_DROP_BAD_EN
        if (crc_sh_q == crc_rx_q) dout_q <= rx_sh_q;
`else
        dout_q <= rx_sh_q;
`endif
      end
      unique case (state_q)
        S_IDLE: begin
          if (ss_fall) begin
            tx_sh_q   <= data_in_slave;
            miso_q    <= data_in_slave[DATA_WIDTH-1];
            crc_rx_q  <= CRC_INIT;
            crc_tx_q  <= CRC_INIT;
            bit_cnt_q <= '0;
          end
        end
        S_DATA: begin
          if (!ss_rise) begin
            if (sclk_rise) begin
              rx_sh_q  <= {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
              crc_rx_q <= crc_step(crc_rx_q, mosi_s);
              crc_tx_q <= crc_step(crc_tx_q, miso_q);
              if (bit_cnt_q == LAST_DATA) bit_cnt_q <= '0;
              else                        bit_cnt_q <= bit_cnt_q + 1'b1;
            end else if (sclk_fall) begin
              miso_q  <= tx_sh_q[DATA_WIDTH-2];
              tx_sh_q <= tx_sh_q << 1;
            end
          end
        end
        S_CRC: begin
          if (!ss_rise) begin
            if (sclk_rise) begin
              crc_sh_q <= {crc_sh_q[6:0], mosi_s};
              if (bit_cnt_q == LAST_CRC) begin
                bit_cnt_q <= '0;
                fin_q     <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end else if (sclk_fall) begin
              // crc_tx is consumed MSB first; shifting exposes the next bit.
              miso_q   <= crc_tx_q[7];
              crc_tx_q <= crc_tx_q << 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_crc_slave.sv
module tb_spi_crc_slave;
  localparam int W = 8;

  logic         clk_s = 1'b0;
  logic         rst_n, ss_n, sclk, mosi, miso;
  logic [W-1:0] data_in_slave, data_out_slave;
  logic         rx_valid, crc_err, busy;
  logic [1:0]   dbg_state;

  spi_crc_slave dut (
    .clk_s          (clk_s),
    .rst_n          (rst_n),
    .ss_n           (ss_n),
    .sclk           (sclk),
    .mosi           (mosi),
    .miso           (miso),
    .data_in_slave  (data_in_slave),
    .data_out_slave (data_out_slave),
    .rx_valid       (rx_valid),
    .crc_err        (crc_err),
    .busy           (busy),
    .dbg_state      (dbg_state)
  );

  // clock / watchdog
  always #5 clk_s = ~clk_s;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [W:0]   exp_q[$];       // {crc_err, data_out_slave}
  logic [15:0]  miso_exp_q[$];  // {returned word, its CRC}
  logic [W-1:0] model_dout;
  logic         model_err;

  // Reference CRC: remainder of (d * x^8) divided by x^8+x^2+x+1 (seed 0).
  function automatic logic [7:0] ref_crc(input logic [7:0] d);
    logic [15:0] r;
    r = {d, 8'h00};
    for (int i = 15; i >= 8; i--)
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    return r[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_s);
  endtask

  // driver tasks
  task automatic start_frame(input logic [7:0] din);
    data_in_slave = din;
    ss_n = 1'b0;
    wait_cyc(8);
    data_in_slave = 8'($urandom_range(0, 255));  // must not affect this frame
  endtask

  task automatic shift_bits(input logic [15:0] word, input int nbits, input int half,
                            output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[15-i];
      wait_cyc(half);
      cap[15-i] = miso;
      sclk = 1'b1;
      wait_cyc(half);
      sclk = 1'b0;
    end
  endtask

  task automatic full_frame(input logic [7:0] din, input logic [7:0] dat,
                            input logic [7:0] crc_sent, input int half);
    logic [15:0] cap, mexp;
    logic        err;
    err = (crc_sent != ref_crc(dat));
    model_err = err;
`ifdef SPI_CRC_SLAVE_DROP_BAD_EN
    if (!err) model_dout = dat;
`else
    model_dout = dat;
`endif
    exp_q.push_back({model_err, model_dout});
    miso_exp_q.push_back({din, ref_crc(din)});
    start_frame(din);
    shift_bits({dat, crc_sent}, 16, half, cap);
    wait_cyc(3);
    ss_n = 1'b1;
    mexp = miso_exp_q.pop_front();
    check("miso_stream", cap, mexp);
    wait_cyc(4);
    check("miso_idle", miso, 1'b0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      wait_cyc(1);
      t++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk_s) begin
    logic [W:0] e;
    if (rst_n === 1'b1 && rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rx_valid: got 1 expected 0 at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", data_out_slave, e[W-1:0]);
        check("rx_crc_err", crc_err, e[W]);
      end
    end
  end

  initial begin
    logic [15:0] cap;
    logic [7:0]  d, c;
    rst_n = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; data_in_slave = '0;
    model_dout = '0; model_err = 1'b0;
    wait_cyc(3);
    check("reset_miso", miso, 0);
    check("reset_dout", data_out_slave, 0);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_crc_err", crc_err, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    wait_cyc(4);

    // good frame at the minimum half-period
    full_frame(8'hF5, 8'hD7, 8'h2B, 4);
    check("t2_ref_crc_tx", ref_crc(8'hF5), 8'hC5);
    wait_cyc(4);
    // good frame at a relaxed half-period
    full_frame(8'hF5, 8'hD7, 8'h2B, 6);
    wait_cyc(4);
    // bad CRC, same payload then a distinct payload
    full_frame(8'h81, 8'hD7, 8'h2A, 5);
    wait_cyc(4);
    full_frame(8'h3C, 8'h5A, ref_crc(8'h5A) ^ 8'h01, 5);
    wait_cyc(4);
    drain();

    // abort after 5 data bits
    start_frame(8'hA5);
    shift_bits(16'h9C00, 5, 5, cap);
    check("abort_busy_mid", busy, 1);
    ss_n = 1'b1;
    wait_cyc(6);
    check("abort_busy", busy, 0);
    check("abort_miso", miso, 0);
    check("abort_dout", data_out_slave, model_dout);
    check("abort_crc_err", crc_err, model_err);
    wait_cyc(4);
    full_frame(8'h00, 8'h00, 8'h00, 5);
    wait_cyc(4);

    // back-to-back with a 4-cycle ss_n gap (full_frame waits 4 after ss_n rise)
    full_frame(8'h12, 8'hD7, 8'h2B, 4);
    full_frame(8'h34, 8'hF5, 8'hC5, 4);
    drain();

    // randomized frames
    for (int k = 0; k < 20; k++) begin
      d = 8'($urandom_range(0, 255));
      c = ref_crc(d);
      if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
      full_frame(8'($urandom_range(0, 255)), d, c, $urandom_range(4, 7));
      wait_cyc($urandom_range(0, 6));
    end
    full_frame(8'h5E, 8'hA7, ref_crc(8'hA7), 5);
    drain();

    // asynchronous reset mid-frame
    start_frame(8'hFF);
    shift_bits(16'hFFFF, 6, 5, cap);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_miso", miso, 0);
    check("t1_dout", data_out_slave, 0);
    check("t1_rx_valid", rx_valid, 0);
    check("t1_crc_err", crc_err, 0);
    check("t1_busy", busy, 0);
    ss_n = 1'b1; sclk = 1'b0;
    model_dout = '0; model_err = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(4);
    full_frame(8'hC3, 8'h6B, ref_crc(8'h6B), 4);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
